ifu: RTL and testbench

Instruction Fetch Unit for the single-issue core. Owns the PC and issues one instruction-memory read at a time over a valid/ready request channel. Buffers the returned word in a one-entry holding register and presents it with its PC to the IDU over a valid/ready handshake. Accepts redirects (taken branch/jump target) from the execute stage and stops permanently on a halt (ebreak).

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu.sv | 193 +++++++++++++++++++
 tb/tb_ifu.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared core definitions used by the instruction fetch unit.
//   CORE_XLEN       default data/address width
//   CORE_RESET_VEC  PC value loaded by reset
//   INST_W          instruction word width
//   ifu_state_e     fetch FSM state encoding
package ifu_pkg;

    localparam int          CORE_XLEN      = 32;
    localparam logic [31:0] CORE_RESET_VEC = 32'h8000_0000;
    localparam int          INST_W         = 32;

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// ifu: instruction fetch unit for the single-issue core.
// Owns the PC, issues one instruction-memory read at a time, buffers the
// returned word in a one-entry holding register and hands it to the IDU.
//
// Ports
//   clk, rst_b                    clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     fetch request channel (addr = pc)
//   imem_rsp_valid/data           fetch response (no backpressure)
//   if_inst_valid/ready           instruction handshake to the IDU
//   if_inst, if_pc                buffered instruction and its PC
//   exu_redirect, exu_redirect_pc one-cycle redirect strobe and target
//   fetch_halt                    stop fetching (sticky until reset)
//   dbg_state                     current fetch FSM state
//
// Handshake rule for every valid/ready pair in this block: a transfer
// happens on a rising edge where valid and ready are both high; the sender
// holds valid and its payload stable until that edge, and ready may be
// driven freely. Redirect and halt are the only things that may retract a
// valid payload before it transfers.
module ifu
    import ifu_pkg::*;
#(
    parameter int               XLEN      = CORE_XLEN,
    parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(CORE_RESET_VEC)
) (
    input  logic              clk,
    input  logic              rst_b,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [XLEN-1:0]   imem_rsp_data,
    output logic              if_inst_valid,
    input  logic              if_inst_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [XLEN-1:0]   if_pc,
    input  logic              exu_redirect,
    input  logic [XLEN-1:0]   exu_redirect_pc,
    input  logic              fetch_halt,
    output logic [2:0]        dbg_state
);

    ifu_state_e        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              halt_pend_q, halt_pend_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;

    logic [XLEN-1:0]   redirect_pc;
    logic              req_fire;

    // Targets are always word aligned; low bits of the request are ignored.
    assign redirect_pc = {exu_redirect_pc[XLEN-1:2], 2'b00};
    assign req_fire    = (state_q == REQ) && imem_req_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            flush_q     <= 1'b0;
            halt_pend_q <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            halt_pend_q <= halt_pend_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = flush_q;
        halt_pend_d = halt_pend_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;

        case (state_q)
            BOOT: begin
                if (fetch_halt) begin
                    state_d = HALT;
                end else begin
                    state_d = REQ;
                    if (exu_redirect) begin
                        pc_d = redirect_pc;
                    end
                end
            end

            REQ: begin
                // If the memory takes the old address in the same cycle that a
                // halt or redirect arrives, a response is now in flight, so it
                // must be waited for and thrown away rather than abandoned.
                if (fetch_halt) begin
                    if (req_fire) begin
                        state_d     = WAIT;
                        flush_d     = 1'b1;
                        halt_pend_d = 1'b1;
                    end else begin
                        state_d = HALT;
                    end
                end else if (exu_redirect) begin
                    pc_d = redirect_pc;
                    if (req_fire) begin
                        state_d = WAIT;
                        flush_d = 1'b1;
                    end
                end else if (req_fire) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (fetch_halt || halt_pend_q) begin
                    // Halt outranks any redirect; the response is absorbed.
                    flush_d     = 1'b1;
                    halt_pend_d = 1'b1;
                    if (imem_rsp_valid) begin
                        state_d     = HALT;
                        flush_d     = 1'b0;
                        halt_pend_d = 1'b0;
                    end
                end else if (exu_redirect) begin
                    pc_d = redirect_pc;
                    if (imem_rsp_valid) begin
                        state_d = REQ;
                        flush_d = 1'b0;
                    end else begin
                        flush_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (flush_q) begin
                        state_d = REQ;
                        flush_d = 1'b0;
                    end else begin
                        state_d   = HOLD;
                        inst_d    = imem_rsp_data[INST_W-1:0];
                        inst_pc_d = pc_q;
                    end
                end
            end

            HOLD: begin
                // Redirect beats ready: a consumed-and-redirected word would
                // otherwise advance the PC past the branch target.
                if (fetch_halt) begin
                    state_d = HALT;
                    inst_d  = '0;
                end else if (exu_redirect) begin
                    state_d = REQ;
                    pc_d    = redirect_pc;
                end else if (if_inst_ready) begin
                    state_d = REQ;
                    pc_d    = pc_q + XLEN'(4);
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = imem_req_valid ? pc_q : '0;
    assign if_inst_valid  = (state_q == HOLD);
    assign if_inst        = inst_q;
    assign if_pc          = inst_pc_q;
    assign dbg_state      = state_q;

`ifndef SYNTHESIS
    a_req_addr_stable: assert property (
        @(posedge clk) disable iff (!rst_b)
        (imem_req_valid && !imem_req_ready && !exu_redirect && !fetch_halt)
            |=> $stable(imem_req_addr)
    ) else $error("ifu: imem_req_addr changed while request pending");

    a_rsp_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst_b)
        imem_rsp_valid |-> (state_q == WAIT)
    ) else $error("ifu: imem_rsp_valid outside WAIT");
`endif

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed bench for the instruction fetch unit. A small memory
// model answers each accepted request after rsp_delay extra cycles with the
// word (addr ^ KEY). Inputs are driven and outputs sampled on the falling edge.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] KEY = 32'h13A5_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_inst_valid;
    logic        if_inst_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        exu_redirect;
    logic [31:0] exu_redirect_pc;
    logic        fetch_halt;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int rsp_delay = 0;

    ifu dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_inst_valid   (if_inst_valid),
        .if_inst_ready   (if_inst_ready),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .exu_redirect    (exu_redirect),
        .exu_redirect_pc (exu_redirect_pc),
        .fetch_halt      (fetch_halt),
        .dbg_state       (dbg_state)
    );

    // ---------------- memory model ----------------
    initial begin
        bit          acc;
        bit          pend;
        int          cnt;
        logic [31:0] acc_addr;
        logic [31:0] pend_addr;
        pend           = 1'b0;
        cnt            = 0;
        pend_addr      = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            acc      = rst_b && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst_b) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend      = 1'b1;
                    cnt       = rsp_delay;
                    pend_addr = acc_addr;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = pend_addr ^ KEY;
                        pend           = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        step();
        step();
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || if_inst_valid !== 1'b0 ||
            if_inst !== 32'h0 || if_pc !== 32'h0 || dbg_state !== BOOT) begin
            errors++;
            $display("FAIL reset_outputs: req_v=%b addr=%h inst_v=%b inst=%h pc=%h st=%0d required all 0, st=0",
                     imem_req_valid, imem_req_addr, if_inst_valid, if_inst, if_pc, dbg_state);
        end
        rst_b = 1'b1;
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL first_req: valid=%b addr=%h required valid=1 addr=80000000",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        if_inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h8000_0000 + 32'(i * 4);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
                errors++;
                $display("FAIL stream_req%0d: valid=%b addr=%h required valid=1 addr=%h",
                         i, imem_req_valid, imem_req_addr, exp_pc);
            end
            step();
            step();
            checks++;
            if (if_inst_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== (exp_pc ^ KEY)) begin
                errors++;
                $display("FAIL stream_inst%0d: valid=%b pc=%h inst=%h required valid=1 pc=%h inst=%h",
                         i, if_inst_valid, if_pc, if_inst, exp_pc, exp_pc ^ KEY);
            end
            step();
        end
    endtask

    task automatic test_stall();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_000C) begin
            errors++;
            $display("FAIL stall_req: valid=%b addr=%h required valid=1 addr=8000000c",
                     imem_req_valid, imem_req_addr);
        end
        if_inst_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (if_inst_valid !== 1'b1 || if_pc !== 32'h8000_000C ||
                if_inst !== (32'h8000_000C ^ KEY) || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: inst_v=%b pc=%h inst=%h req_v=%b required 1 8000000c %h 0",
                         i, if_inst_valid, if_pc, if_inst, imem_req_valid, 32'h8000_000C ^ KEY);
            end
            if (i < 4) step();
        end
        if_inst_ready = 1'b1;
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0010) begin
            errors++;
            $display("FAIL stall_next_req: valid=%b addr=%h required valid=1 addr=80000010",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit saw_inst;
        bit got_req;
        int waited;
        saw_inst  = 1'b0;
        got_req   = 1'b0;
        waited    = -1;
        rsp_delay = 2;
        step();
        checks++;
        if (dbg_state !== WAIT) begin
            errors++;
            $display("FAIL rdw_in_wait: state=%0d required %0d", dbg_state, WAIT);
        end
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'h8000_0103;
        step();
        exu_redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (if_inst_valid === 1'b1) saw_inst = 1'b1;
            if (imem_req_valid === 1'b1) begin
                got_req = 1'b1;
                waited  = i;
                break;
            end
            step();
        end
        rsp_delay = 0;
        checks++;
        if (!got_req || saw_inst || imem_req_addr !== 32'h8000_0100 || waited != 2) begin
            errors++;
            $display("FAIL rdw_next_req: got=%b saw_inst=%b addr=%h wait=%0d required 1 0 80000100 2",
                     got_req, saw_inst, imem_req_addr, waited);
        end
    endtask

    task automatic test_redirect_rsp_same();
        step();
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'h8000_0200;
        step();
        exu_redirect = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200 || if_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_rsp_same: req_v=%b addr=%h inst_v=%b required 1 80000200 0",
                     imem_req_valid, imem_req_addr, if_inst_valid);
        end
    endtask

    task automatic test_redirect_hold();
        if_inst_ready = 1'b0;
        step();
        step();
        checks++;
        if (if_inst_valid !== 1'b1 || if_pc !== 32'h8000_0200) begin
            errors++;
            $display("FAIL rdh_hold: inst_v=%b pc=%h required 1 80000200", if_inst_valid, if_pc);
        end
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'h8000_1000;
        if_inst_ready   = 1'b1;
        step();
        exu_redirect = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_1000 || if_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdh_next_req: req_v=%b addr=%h inst_v=%b required 1 80001000 0",
                     imem_req_valid, imem_req_addr, if_inst_valid);
        end
    endtask

    task automatic test_wrap();
        imem_req_ready  = 1'b0;
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'hFFFF_FFFF;
        step();
        exu_redirect = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_redirect: valid=%b addr=%h required 1 fffffffc",
                     imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        step();
        step();
        checks++;
        if (if_inst_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_inst !== (32'hFFFF_FFFC ^ KEY)) begin
            errors++;
            $display("FAIL wrap_inst: valid=%b pc=%h inst=%h required 1 fffffffc %h",
                     if_inst_valid, if_pc, if_inst, 32'hFFFF_FFFC ^ KEY);
        end
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_next_req: valid=%b addr=%h required 1 00000000",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_halt();
        bit bad;
        bit halted;
        int waited;
        bad       = 1'b0;
        halted    = 1'b0;
        waited    = -1;
        rsp_delay = 4;
        step();
        fetch_halt      = 1'b1;
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'h0000_0040;
        step();
        fetch_halt   = 1'b0;
        exu_redirect = 1'b0;
        checks++;
        if (dbg_state !== WAIT || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_absorb: state=%0d req_v=%b required %0d 0", dbg_state, imem_req_valid, WAIT);
        end
        for (int i = 0; i < 12; i++) begin
            if (imem_req_valid === 1'b1 || if_inst_valid === 1'b1) bad = 1'b1;
            if (dbg_state === HALT) begin
                halted = 1'b1;
                waited = i;
                break;
            end
            step();
        end
        rsp_delay = 0;
        checks++;
        if (!halted || bad || waited != 4) begin
            errors++;
            $display("FAIL halt_enter: halted=%b bad=%b wait=%0d required 1 0 4", halted, bad, waited);
        end
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'h8000_0000;
        if_inst_ready   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (imem_req_valid !== 1'b0 || if_inst_valid !== 1'b0 || dbg_state !== HALT) begin
                errors++;
                $display("FAIL halt_sticky%0d: req_v=%b inst_v=%b state=%0d required 0 0 %0d",
                         i, imem_req_valid, if_inst_valid, dbg_state, HALT);
            end
        end
        exu_redirect = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst_b = 1'b0;
        #1;
        checks++;
        if (dbg_state !== BOOT || imem_req_valid !== 1'b0 || if_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d req_v=%b inst_v=%b required 0 0 0",
                     dbg_state, imem_req_valid, if_inst_valid);
        end
        step();
        fetch_halt = 1'b1;
        rst_b      = 1'b1;
        step();
        fetch_halt = 1'b0;
        checks++;
        if (dbg_state !== HALT || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_halt: state=%0d req_v=%b required %0d 0", dbg_state, imem_req_valid, HALT);
        end
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        step();
        rsp_delay = 1;
        step();
        rst_b = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || if_inst !== 32'h0 || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_in_wait: req_v=%b addr=%h inst=%h pc=%h required all 0",
                     imem_req_valid, imem_req_addr, if_inst, if_pc);
        end
        rsp_delay = 0;
        step();
        step();
        rst_b = 1'b1;
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL restart_req: valid=%b addr=%h required 1 80000000",
                     imem_req_valid, imem_req_addr);
        end
        step();
        step();
        checks++;
        if (if_inst_valid !== 1'b1 || if_pc !== 32'h8000_0000 || if_inst !== (32'h8000_0000 ^ KEY)) begin
            errors++;
            $display("FAIL restart_inst: valid=%b pc=%h inst=%h required 1 80000000 %h",
                     if_inst_valid, if_pc, if_inst, 32'h8000_0000 ^ KEY);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_b           = 1'b0;
        imem_req_ready  = 1'b1;
        if_inst_ready   = 1'b0;
        exu_redirect    = 1'b0;
        exu_redirect_pc = '0;
        fetch_halt      = 1'b0;

        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp_same();
        test_redirect_hold();
        test_wrap();
        test_halt();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_ifu watchdog");
    end

endmodule
